// File: rtl/regfile_mp.sv
// Multi-read-port register file with x0 hard-wired to zero and a sequenced bulk-clear engine.
// Optional write-through forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    parameter int  NUM_RD = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [XLEN-1:0]          wr_data_i,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o,
    output logic                     clr_done_o,
    output logic                     wr_drop_o
);

    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [AW-1:0]     ptr_q;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic              clr_busy_q;
    logic              clr_done_q;
    logic              wr_drop_q;

    logic              wr_addr_ok;
    logic              wr_accept;
    logic              wr_drop_d;

    assign wr_addr_ok = (wr_addr_i != '0) && ({1'b0, wr_addr_i} < NREGS_W);
    assign wr_accept  = wr_en_i && wr_addr_ok && (state_q == S_IDLE);
    // Only writes that would otherwise have landed are reported as dropped.
    assign wr_drop_d  = wr_en_i && wr_addr_ok && (state_q != S_IDLE);

    always_comb begin
        logic [AW-1:0] ra;
        ra        = '0;
        rd_data_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr_i[k*AW +: AW];
            if ((ra != '0) && ({1'b0, ra} < NREGS_W)) begin
                rd_data_o[k*XLEN +: XLEN] = regs_q[ra];
            end
`ifdef REGFILE_BYPASS_EN
            // Forward only writes that will actually commit at the coming edge.
            if (rst_n && wr_accept && (ra == wr_addr_i)) begin
                rd_data_o[k*XLEN +: XLEN] = wr_data_i;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            wr_drop_q  <= wr_drop_d;
            if (wr_accept) begin
                regs_q[wr_addr_i] <= wr_data_i;
            end
            case (state_q)
                S_IDLE: begin
                    if (clr_req_i) begin
                        ptr_q      <= AW'(1);
                        state_q    <= S_CLEAR;
                        clr_busy_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    regs_q[ptr_q] <= '0;
                    ptr_q         <= ptr_q + AW'(1);
                    if (ptr_q == LAST) begin
                        state_q    <= S_DONE;
                        clr_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    clr_busy_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy_o = clr_busy_q;
    assign clr_done_o = clr_done_q;
    assign wr_drop_o  = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic                   clr_req;
    logic                   clr_busy;
    logic                   clr_done;
    logic                   wr_drop;

    int checks = 0;
    int errors = 0;

    // Reference state: register contents plus the clear progress counter.
    // phase 0 = idle, 1..NREGS-1 = clearing register 'phase', NREGS = done cycle.
    logic [XLEN-1:0] model [NREGS];
    int              phase;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .clr_req_i  (clr_req),
        .clr_busy_o (clr_busy),
        .clr_done_o (clr_done),
        .wr_drop_o  (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] rd_port(input int k);
        return rd_data[k*XLEN +: XLEN];
    endfunction

    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (a != 0) && (int'(a) < NREGS);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        phase = 0;
    endtask

    // Check reads before the edge, advance the model across the edge, then check control outputs.
    task automatic cycle();
        logic            acc;
        logic            drop_exp;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] exp;
        @(negedge clk);
        acc = wr_en && (phase == 0) && addr_valid(wr_addr);
        for (int k = 0; k < NUM_RD; k++) begin
            a   = rd_addr[k*AW +: AW];
            exp = addr_valid(a) ? model[a] : '0;
`ifdef REGFILE_BYPASS_EN
            if (acc && a == wr_addr) exp = wr_data;
`endif
            chk("rd", rd_port(k), exp);
        end
        @(posedge clk);
        drop_exp = wr_en && (phase != 0) && addr_valid(wr_addr);
        if (phase == 0) begin
            if (acc) model[wr_addr] = wr_data;
            if (clr_req) phase = 1;
        end else if (phase < NREGS) begin
            model[phase] = '0;
            phase++;
        end else begin
            phase = 0;
        end
        #1;
        chk("busy", clr_busy, phase != 0);
        chk("done", clr_done, phase == NREGS);
        chk("drop", wr_drop, drop_exp);
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < NREGS; a++) begin
            set_rd(0, a);
            set_rd(1, a);
            #1;
            chk(tag, rd_data, '0);
        end
    endtask

    initial begin
        int n;
        int drops;
        logic [XLEN-1:0] old7;
        rst_n   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_req = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_done", clr_done, 1'b0);
        chk("rst_drop", wr_drop, 1'b0);
        sweep_zero("rst_rd");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write x5 then read it on port 0 while port 1 reads x0
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        cycle();
        wr_en = 1'b0; set_rd(0, 5); set_rd(1, 0);
        #1;
        chk("x5_p0", rd_port(0), 32'hDEADBEEF);
        chk("x5_p1", rd_port(1), 32'h0);
        cycle();

        // Write to x0 is silently ignored
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234; set_rd(0, 0);
        cycle();
        wr_en = 1'b0;
        #1;
        chk("x0_rd", rd_port(0), 32'h0);
        chk("x0_drop", wr_drop, 1'b0);

        // Same-cycle write and read of x7
        old7 = model[7];
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5; set_rd(1, 7);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x7_same", rd_port(1), 32'hA5A5A5A5);
`else
        chk("x7_same", rd_port(1), old7);
`endif
        cycle();
        wr_en = 1'b0;
        #1;
        chk("x7_after", rd_port(1), 32'hA5A5A5A5);

        // Fill, clear, and attempt a write during the clear
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'h01010101 * i + 32'h10;
            set_rd(0, i); set_rd(1, NREGS - i);
            cycle();
        end
        wr_en = 1'b0; clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        n = 1; drops = 0;
        while (!clr_done && n < 100) begin
            wr_en = (n == 5); wr_addr = 3; wr_data = 32'hCAFE0003;
            set_rd(0, 3); set_rd(1, n % NREGS);
            cycle();
            if (wr_drop) drops++;
            n++;
        end
        wr_en = 1'b0;
        chk("done_cycle", n, NREGS);
        chk("drop_cnt", drops, 1);
        cycle();
        chk("idle_after", clr_busy, 1'b0);
        sweep_zero("clr_zero");

        // Reset in the middle of a clear
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = $urandom | 32'h1;
            cycle();
        end
        wr_en = 1'b0; clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        repeat (9) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_busy", clr_busy, 1'b0);
        chk("mid_rst_done", clr_done, 1'b0);
        sweep_zero("mid_rst_rd");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NREGS + 4) cycle();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom_range(0, NREGS - 1));
            wr_data = $urandom;
            clr_req = ($urandom_range(0, 39) == 0);
            set_rd(0, $urandom_range(0, NREGS - 1));
            set_rd(1, ($urandom_range(0, 3) == 0) ? int'(wr_addr) : $urandom_range(0, NREGS - 1));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
